// File: rtl/stopwatch_core.sv
// Stopwatch: IDLE/RUN/STOP control with an h:m:s.ms counter chain advanced by a tick pulse.
// All outputs are registered and change one clk after the causing input; there is no backpressure.
module stopwatch_core #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int HOURS_MAX     = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_run_stop,
  input  logic       i_clear,
  output logic [9:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_state,
  output logic       o_rollover
);

  localparam int MSW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HW  = (HOURS_MAX > 1) ? $clog2(HOURS_MAX) : 1;

  localparam logic [MSW-1:0] MSEC_LAST = MSW'(TICKS_PER_SEC - 1);
  localparam logic [5:0]     SEC_LAST  = 6'd59;
  localparam logic [5:0]     MIN_LAST  = 6'd59;
  localparam logic [HW-1:0]  HOUR_LAST = HW'(HOURS_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10
  } state_t;

  state_t         state;
  logic [MSW-1:0] msec;
  logic [5:0]     sec;
  logic [5:0]     min;
  logic [HW-1:0]  hour;
  logic           rollover;

  logic count;
  logic msec_wrap;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;

  // Counting follows the registered state, so a tick alongside a start command is not counted
  // while a tick alongside a stop command still is.
  assign count     = (state == RUN) && i_tick;
  assign msec_wrap = (msec == MSEC_LAST);
  assign sec_wrap  = (sec == SEC_LAST);
  assign min_wrap  = (min == MIN_LAST);
  assign hour_wrap = (hour == HOUR_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      msec     <= '0;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      rollover <= 1'b0;
    end else begin
      rollover <= 1'b0;

      if (count) begin
        msec <= msec_wrap ? '0 : msec + MSW'(1);
        if (msec_wrap)
          sec <= sec_wrap ? '0 : sec + 6'd1;
        if (msec_wrap && sec_wrap)
          min <= min_wrap ? '0 : min + 6'd1;
        if (msec_wrap && sec_wrap && min_wrap)
          hour <= hour_wrap ? '0 : hour + HW'(1);
        rollover <= msec_wrap && sec_wrap && min_wrap && hour_wrap;
      end

      case (state)
        IDLE: begin
          if (i_run_stop)
            state <= RUN;
        end
        RUN: begin
          if (i_run_stop)
            state <= STOP;
        end
        STOP: begin
          if (i_clear) begin
            state <= IDLE;
            msec  <= '0;
            sec   <= '0;
            min   <= '0;
            hour  <= '0;
          end else if (i_run_stop) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_msec     = 10'(msec);
  assign o_sec      = sec;
  assign o_min      = min;
  assign o_hour     = 5'(hour);
  assign o_state    = state;
  assign o_rollover = rollover;

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1000, meaning i_tick pulses per second.
REQ-002 SHALL have parameter HOURS_MAX, default 24, meaning the hour count wraps to 0 at this value.
REQ-003 SHALL have port clk, input, 1 bit, system clock (100 MHz).
REQ-004 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-005 SHALL have port i_tick, input, 1 bit, 1-cycle 1 kHz time-base pulse.
REQ-006 SHALL have port i_run_stop, input, 1 bit, 1-cycle debounced run/stop command pulse.
REQ-007 SHALL have port i_clear, input, 1 bit, 1-cycle debounced clear command pulse.
REQ-008 SHALL have port o_msec, output, 10 bits, milliseconds 0..TICKS_PER_SEC-1.
REQ-009 SHALL have port o_sec, output, 6 bits, seconds 0..59.
REQ-010 SHALL have port o_min, output, 6 bits, minutes 0..59.
REQ-011 SHALL have port o_hour, output, 5 bits, hours 0..HOURS_MAX-1.
REQ-012 SHALL have port o_state, output, 2 bits, current FSM state (IDLE=00, RUN=01, STOP=10).
REQ-013 SHALL have port o_rollover, output, 1 bit, 1-cycle pulse on full wrap to 0:00:00.000.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, RUN, STOP; encoding 11 SHALL be unreachable and SHALL return to IDLE on the next clk.
REQ-015 SHALL transition IDLE->RUN on i_run_stop; RUN->STOP on i_run_stop; STOP->RUN on i_run_stop; STOP->IDLE on i_clear.
REQ-016 SHALL ignore i_clear in RUN and in IDLE (counters stay as they are).
REQ-017 SHALL give i_clear priority over i_run_stop when both are asserted in the same cycle in STOP (result IDLE, counters zero).
REQ-018 SHALL use i_run_stop alone when both are asserted in RUN or IDLE.
REQ-019 SHALL zero all counters in the same clk edge that performs STOP->IDLE.
REQ-020 SHALL advance counters only when the registered state is RUN and i_tick=1 on that edge; a tick in the same cycle as the IDLE->RUN or STOP->RUN command SHALL NOT be counted; a tick in the same cycle as the RUN->STOP command SHALL be counted.
REQ-021 SHALL, per counted tick: increment o_msec; at TICKS_PER_SEC-1 wrap o_msec to 0 and carry into o_sec.
REQ-022 SHALL wrap o_sec 59->0 with carry into o_min, and wrap o_min 59->0 with carry into o_hour.
REQ-023 SHALL wrap o_hour HOURS_MAX-1->0; all carries SHALL resolve in the same edge (single-cycle ripple, no multi-cycle carry).
REQ-024 SHALL assert o_rollover for exactly one cycle, registered, on the edge where all four counters wrap to zero simultaneously; otherwise 0.
REQ-025 SHALL register all outputs, updating them on the clk edge following the input event (1-cycle latency from i_tick to o_msec change).
REQ-026 SHALL hold all counters unchanged in STOP and IDLE regardless of i_tick.
REQ-027 SHALL compute counter widths from parameters with $clog2; out-of-range values SHALL never be produced.

Reset
REQ-028 SHALL, on reset=1, asynchronously force o_state=IDLE, o_msec=o_sec=o_min=o_hour=0, o_rollover=0.
REQ-029 SHALL discard any tick or command arriving while reset is high; operation SHALL resume on the first clk edge after reset deasserts.
REQ-030 SHALL restart from IDLE with zero counters when reset is asserted mid-RUN.

Verification
REQ-031 SHALL be verified by: reset, i_run_stop, 1500 ticks -> o_state=RUN, o_sec=1, o_msec=500.
REQ-032 SHALL be verified by: in RUN at 0:00:59.999, one tick -> 0:01:00.000, o_rollover=0.
REQ-033 SHALL be verified by: forcing 23:59:59.999 in RUN, one tick -> 0:00:00.000 with o_rollover high for exactly one cycle.
REQ-034 SHALL be verified by: RUN->STOP at 0:00:02.345, then 50 ticks -> counters unchanged; i_clear -> IDLE and all zero next cycle.
REQ-035 SHALL be verified by: i_run_stop and i_clear in the same cycle in STOP -> IDLE, zero; the same pair in RUN -> STOP, counters kept.
REQ-036 SHALL be verified by: reset pulse mid-RUN at 0:00:05.000 -> immediate (asynchronous) IDLE and zero counters; ticks during reset ignored.
